game_flow_ctrl: RTL

Top-level game sequencer that owns the 4-bit game `state` consumed by the stage timer, the display and the scene logic. It advances title → staff → three stages with success screens and a fail screen. Inputs are the start button, stage-clear and player-death events, and the timer's packed BCD mm:ss readout. It enforces a per-stage time limit and latches each stage's clear time against a per-stage best-time record.

---
 rtl/game_pkg.sv | 22 ++
 rtl/rise_detect.sv | 21 ++
 rtl/game_flow_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: state encodings used by the sequencer, timer and display,
// plus the BCD sentinel values.
package game_pkg;

  localparam logic [3:0] TITLE    = 4'd0;
  localparam logic [3:0] STAFF    = 4'd1;
  localparam logic [3:0] STAGE1   = 4'd2;
  localparam logic [3:0] SUCCESS1 = 4'd3;
  localparam logic [3:0] STAGE2   = 4'd4;
  localparam logic [3:0] SUCCESS2 = 4'd5;
  localparam logic [3:0] STAGE3   = 4'd6;
  localparam logic [3:0] SUCCESS3 = 4'd7;
  localparam logic [3:0] FAIL     = 4'd8;

  localparam logic [15:0] BCD_BLANK = 16'hAAAA;
  localparam logic [15:0] BCD_MAX   = 16'h9999;

  function automatic logic is_stage(input logic [3:0] s);
    return (s == STAGE1) || (s == STAGE2) || (s == STAGE3);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a synchronous level input; the delay register's reset
// value is selectable so a level held through reset can be made not to fire.
module rise_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= RST_VAL;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: title, staff roll, three timed stages with success screens and a
// fail screen; captures each clear time and keeps a per-stage best-time record.
//
// state    | meaning
// TITLE    | waiting for start
// STAFF    | staff roll, auto-advances after STAFF_CYCLES
// STAGEn   | playing stage n, time limit enforced
// SUCCESSn | stage n cleared; 1 and 2 auto-advance after DWELL_CYCLES
// FAIL     | died or ran out of time, start returns to TITLE
// 9..15    | illegal, recovers to TITLE
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter logic [15:0] TIME_LIMIT   = 16'h0300,
  parameter int unsigned DWELL_CYCLES = 200_000_000,
  parameter int unsigned STAFF_CYCLES = 300_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stage_clear,
  input  logic        player_dead,
  input  logic [15:0] nums,
  output logic [3:0]  state,
  output logic        state_entry,
  output logic [15:0] last_time,
  output logic        new_record
);

  localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);
  localparam logic [31:0] STAFF_LAST = 32'(STAFF_CYCLES - 1);

  logic        start_rise;
  logic [3:0]  nxt;
  logic        win;
  logic        failed;
  logic        beat;
  logic [31:0] cnt;
  logic [15:0] best [4];

  rise_detect #(.RST_VAL(1'b1)) u_start_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (start),
    .rise  (start_rise)
  );

  // nums is a straight unsigned compare; BCD ordering matches binary ordering
  assign failed = player_dead || (nums >= TIME_LIMIT);
  assign beat   = nums < best[state[2:1]];

  always_comb begin
    nxt = state;
    win = 1'b0;
    case (state)
      TITLE:    if (start_rise) nxt = STAFF;
      STAFF:    if (start_rise || cnt == STAFF_LAST) nxt = STAGE1;
      STAGE1, STAGE2, STAGE3: begin
        if (failed) begin
          nxt = FAIL;
        end else if (stage_clear) begin
          nxt = state + 4'd1;
          win = 1'b1;
        end
      end
      SUCCESS1: if (start_rise || cnt == DWELL_LAST) nxt = STAGE2;
      SUCCESS2: if (start_rise || cnt == DWELL_LAST) nxt = STAGE3;
      SUCCESS3, FAIL: if (start_rise) nxt = TITLE;
      default:  nxt = TITLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= TITLE;
      state_entry <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= nxt;
      state_entry <= (nxt != state);
      if (nxt != state)  cnt <= '0;
      else if (cnt != '1) cnt <= cnt + 32'd1;
    end
  end

  // best[0] is never addressed; stages 1..3 map onto state[2:1]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_time  <= 16'h0000;
      new_record <= 1'b0;
      for (int i = 0; i < 4; i++) best[i] <= BCD_MAX;
    end else begin
      if (win) begin
        last_time  <= nums;
        new_record <= beat;
        if (beat) best[state[2:1]] <= nums;
      end else if (nxt != state && is_stage(nxt)) begin
        new_record <= 1'b0;
      end
    end
  end

endmodule
